// File: rtl/mux_scan_reg_pkg.sv
// Shared types and helpers for the registered scanning multiplexer.
// Latency: n/a (package). Backpressure: n/a.
// mode_e doubles as the FSM state type in the top level.
package mux_scan_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    // Index width for n items, never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_scan_reg_if.sv
// Bus between the data sources/controller and the scanning multiplexer.
// Latency: n/a (wiring only). Backpressure: none, the consumer must accept every q_valid.
// master drives control and data; slave returns the registered selection.
interface mux_scan_reg_if
    import mux_scan_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 1
) ();

    localparam int SELW = sel_width(N_CH);

    logic                    en;
    logic                    mode;
    logic [SELW-1:0]         sel;
    logic [N_CH*WIDTH-1:0]   d;
    logic [WIDTH-1:0]        q;
    logic [SELW-1:0]         q_ch;
    logic                    q_valid;
    logic                    wrap;
    logic                    sel_err;

    modport master (
        output en, mode, sel, d,
        input  q, q_ch, q_valid, wrap, sel_err
    );

    modport slave (
        input  en, mode, sel, d,
        output q, q_ch, q_valid, wrap, sel_err
    );

endinterface

// File: rtl/mux_scan_reg_scan_counter.sv
// Dwell and channel counters that pace the automatic scan.
// Latency: ch updates on the clock after an advance. Backpressure: holds while adv_en=0.
// clr together with adv_en steps from a zeroed counter, so the entry cycle counts as dwell cycle 0.
module scan_counter
    import mux_scan_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int DWELL = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          adv_en,
    output logic [sel_width(N_CH)-1:0]    ch,
    output logic                          wrap_pulse
);

    localparam int SELW = sel_width(N_CH);
    localparam int CW   = sel_width(DWELL);

    localparam logic [SELW-1:0] CH_LAST  = SELW'(N_CH - 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);

    logic [SELW-1:0] ch_q;
    logic [SELW-1:0] base_ch;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   base_cnt;
    logic            wrapped_q;

    assign base_ch  = clr ? '0 : ch_q;
    assign base_cnt = clr ? '0 : cnt_q;

    // wrapped_q marks that ch has just rolled to 0 but has not been shown yet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_q      <= '0;
            cnt_q     <= '0;
            wrapped_q <= 1'b0;
        end else if (adv_en) begin
            if (base_cnt == CNT_LAST) begin
                cnt_q     <= '0;
                ch_q      <= (base_ch == CH_LAST) ? '0 : base_ch + SELW'(1);
                wrapped_q <= (base_ch == CH_LAST);
            end else begin
                cnt_q     <= base_cnt + CW'(1);
                ch_q      <= base_ch;
                wrapped_q <= 1'b0;
            end
        end else if (clr) begin
            ch_q      <= '0;
            cnt_q     <= '0;
            wrapped_q <= 1'b0;
        end
    end

    assign ch         = ch_q;
    assign wrap_pulse = wrapped_q;

endmodule

// File: rtl/mux_scan_reg.sv
// Registered N-channel multiplexer with manual select and timed automatic scan.
// Latency: 1 cycle from d/sel to q, all outputs registered. Backpressure: none; en=0 freezes state.
// Every word is tagged with its channel; out-of-range manual selects raise sel_err.
module mux_scan_reg
    import mux_scan_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 1,
    parameter int DWELL = 4
) (
    input  logic           clk,
    input  logic           rst,
    mux_scan_reg_if.slave  bus
);

    localparam int              SELW   = sel_width(N_CH);
    localparam logic [SELW:0]   N_CH_W = (SELW + 1)'(N_CH);

    mode_e           state_q;
    mode_e           state_d;

    logic            entry;
    logic            scan_step;
    logic            in_range;
    logic [SELW-1:0] mux_sel;
    logic [WIDTH-1:0] data;
    logic [SELW-1:0] ch;
    logic            wrap_pulse;

    logic [WIDTH-1:0] q_q,       q_d;
    logic [SELW-1:0]  q_ch_q,    q_ch_d;
    logic             q_valid_q, q_valid_d;
    logic             wrap_q,    wrap_d;
    logic             sel_err_q, sel_err_d;

    scan_counter #(
        .N_CH  (N_CH),
        .DWELL (DWELL)
    ) u_scan_counter (
        .clk        (clk),
        .rst        (rst),
        .clr        (entry),
        .adv_en     (scan_step),
        .ch         (ch),
        .wrap_pulse (wrap_pulse)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MODE_MANUAL;
        end else begin
            state_q <= state_d;
        end
    end

    // The mode input decides this cycle's behaviour; state only tells us whether scan is being entered.
    always_comb begin
        state_d   = state_q;
        entry     = 1'b0;
        scan_step = 1'b0;
        mux_sel   = bus.sel;
        in_range  = 1'b0;
        data      = '0;
        q_d       = q_q;
        q_ch_d    = q_ch_q;
        q_valid_d = 1'b0;
        wrap_d    = 1'b0;
        sel_err_d = sel_err_q;

        if (bus.en) begin
            if (mode_e'(bus.mode) == MODE_SCAN) begin
                state_d   = MODE_SCAN;
                scan_step = 1'b1;
                entry     = (state_q == MODE_MANUAL);
                mux_sel   = entry ? '0 : ch;
            end else begin
                state_d   = MODE_MANUAL;
            end
        end

        in_range = ({1'b0, mux_sel} < N_CH_W);
        if (in_range) begin
            data = bus.d[int'(mux_sel) * WIDTH +: WIDTH];
        end

        if (bus.en) begin
            q_ch_d = mux_sel;
            q_d    = data;
            if (scan_step) begin
                q_valid_d = 1'b1;
                wrap_d    = wrap_pulse && !entry;
            end else begin
                q_valid_d = in_range;
                sel_err_d = !in_range;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q       <= '0;
            q_ch_q    <= '0;
            q_valid_q <= 1'b0;
            wrap_q    <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            q_ch_q    <= q_ch_d;
            q_valid_q <= q_valid_d;
            wrap_q    <= wrap_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign bus.q       = q_q;
    assign bus.q_ch    = q_ch_q;
    assign bus.q_valid = q_valid_q;
    assign bus.wrap    = wrap_q;
    assign bus.sel_err = sel_err_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Bench for mux_scan_reg: a 4x1-bit DWELL=2 instance and a 5x8-bit DWELL=1 instance share clk/rst.
// Expected outputs come from a position-based scan model (channel = (steps/DWELL) mod N_CH).
module tb_mux_scan_reg;

    localparam int A_N = 4, A_W = 1, A_D = 2;
    localparam int B_N = 5, B_W = 8, B_D = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_scan_reg_if #(.N_CH(A_N), .WIDTH(A_W)) bus_a ();
    mux_scan_reg_if #(.N_CH(B_N), .WIDTH(B_W)) bus_b ();

    mux_scan_reg #(.N_CH(A_N), .WIDTH(A_W), .DWELL(A_D)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    mux_scan_reg #(.N_CH(B_N), .WIDTH(B_W), .DWELL(B_D)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    bit         m_scan  [2];
    int         m_p     [2];
    logic [7:0] m_q     [2];
    int         m_qch   [2];
    logic       m_valid [2];
    logic       m_wrap  [2];
    logic       m_err   [2];

    logic [5:0]  oa, ea;
    logic [13:0] ob, eb;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_scan[k]  = 1'b0;
            m_p[k]     = 0;
            m_q[k]     = '0;
            m_qch[k]   = 0;
            m_valid[k] = 1'b0;
            m_wrap[k]  = 1'b0;
            m_err[k]   = 1'b0;
        end
    endtask

    task automatic model_tick();
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            int n, w, dw, sel, ch;
            logic en, mode;
            logic [63:0] d, mask;
            if (k == 0) begin
                n = A_N; w = A_W; dw = A_D;
                en = bus_a.en; mode = bus_a.mode; sel = int'(bus_a.sel); d = 64'(bus_a.d);
            end else begin
                n = B_N; w = B_W; dw = B_D;
                en = bus_b.en; mode = bus_b.mode; sel = int'(bus_b.sel); d = 64'(bus_b.d);
            end
            mask = (64'd1 << w) - 64'd1;
            if (!en) begin
                m_valid[k] = 1'b0;
                m_wrap[k]  = 1'b0;
            end else if (mode) begin
                if (!m_scan[k]) begin
                    m_scan[k] = 1'b1;
                    m_p[k]    = 0;
                end
                ch         = (m_p[k] / dw) % n;
                m_q[k]     = 8'((d >> (ch * w)) & mask);
                m_qch[k]   = ch;
                m_valid[k] = 1'b1;
                m_wrap[k]  = (m_p[k] != 0) && (m_p[k] % (dw * n) == 0);
                m_p[k]     = m_p[k] + 1;
            end else begin
                m_scan[k] = 1'b0;
                m_qch[k]  = sel;
                m_wrap[k] = 1'b0;
                if (sel < n) begin
                    m_q[k]     = 8'((d >> (sel * w)) & mask);
                    m_valid[k] = 1'b1;
                    m_err[k]   = 1'b0;
                end else begin
                    m_q[k]     = '0;
                    m_valid[k] = 1'b0;
                    m_err[k]   = 1'b1;
                end
            end
        end
    endtask

    task automatic snap();
        oa = {bus_a.q, bus_a.q_ch, bus_a.q_valid, bus_a.wrap, bus_a.sel_err};
        ea = {m_q[0][0], m_qch[0][1:0], m_valid[0], m_wrap[0], m_err[0]};
        ob = {bus_b.q, bus_b.q_ch, bus_b.q_valid, bus_b.wrap, bus_b.sel_err};
        eb = {m_q[1], m_qch[1][2:0], m_valid[1], m_wrap[1], m_err[1]};
    endtask

    task automatic cycle();
        @(posedge clk);
        model_tick();
        #1;
        snap();
    endtask

    task automatic drive_a(input logic en, input logic mode, input int sel, input logic [3:0] d);
        bus_a.en = en; bus_a.mode = mode; bus_a.sel = 2'(sel); bus_a.d = d;
    endtask

    task automatic drive_b(input logic en, input logic mode, input int sel, input logic [39:0] d);
        bus_b.en = en; bus_b.mode = mode; bus_b.sel = 3'(sel); bus_b.d = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_a(1'b0, 1'b0, 0, 4'h0);
        drive_b(1'b0, 1'b0, 0, 40'h0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        snap();
        n_cmp++;
        if (oa !== ea) begin n_fail++; $display("FAIL reset_a: got %b want %b", oa, ea); end
        n_cmp++;
        if (ob !== eb) begin n_fail++; $display("FAIL reset_b: got %h want %h", ob, eb); end
        rst = 1'b0;
    endtask

    task automatic test_manual();
        logic [3:0] dq = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 1'b0, i, dq);
            cycle();
            n_cmp++;
            if (oa !== ea || bus_a.q !== dq[i] || bus_a.q_ch !== 2'(i) || bus_a.q_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL manual_fixed sel=%0d: got %b want %b (q want %b)", i, oa, ea, dq[i]);
            end
        end
        for (int i = 0; i < 12; i++) begin
            drive_a(1'b1, 1'b0, $urandom_range(0, 3), 4'($urandom));
            cycle();
            n_cmp++;
            if (oa !== ea) begin n_fail++; $display("FAIL manual_rand %0d: got %b want %b", i, oa, ea); end
        end
    endtask

    task automatic test_scan();
        int         qch_exp [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        logic [8:0] q_exp    = 9'b000111100;
        logic [8:0] wrap_exp = 9'b100000000;
        drive_a(1'b1, 1'b1, 0, 4'b0110);
        for (int i = 0; i < 9; i++) begin
            cycle();
            n_cmp++;
            if (oa !== ea || bus_a.q_ch !== 2'(qch_exp[i]) || bus_a.q !== q_exp[i] ||
                bus_a.wrap !== wrap_exp[i] || bus_a.q_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL scan_fixed cyc %0d: got %b want %b (q_ch want %0d)", i, oa, ea, qch_exp[i]);
            end
        end
        for (int i = 0; i < 10; i++) begin
            drive_a(1'b1, 1'b1, 0, 4'($urandom));
            cycle();
            n_cmp++;
            if (oa !== ea) begin n_fail++; $display("FAIL scan_rand %0d: got %b want %b", i, oa, ea); end
        end
    endtask

    task automatic test_sel_err();
        logic [39:0] d;
        drive_b(1'b1, 1'b0, 6, 40'({$urandom, $urandom}));
        cycle();
        n_cmp++;
        if (ob !== eb || bus_b.q !== 8'h00 || bus_b.q_valid !== 1'b0 || bus_b.sel_err !== 1'b1) begin
            n_fail++; $display("FAIL sel_err_set: got %h want %h", ob, eb);
        end
        d = {8'hA5, $urandom};
        drive_b(1'b1, 1'b0, 4, d);
        cycle();
        n_cmp++;
        if (ob !== eb || bus_b.q !== 8'hA5 || bus_b.q_valid !== 1'b1 || bus_b.sel_err !== 1'b0) begin
            n_fail++; $display("FAIL sel_err_clear: got %h want %h", ob, eb);
        end
        for (int i = 0; i < 12; i++) begin
            drive_b(1'b1, 1'b0, $urandom_range(3, 7), 40'({$urandom, $urandom}));
            cycle();
            n_cmp++;
            if (ob !== eb) begin n_fail++; $display("FAIL sel_range %0d: got %h want %h", i, ob, eb); end
        end
    endtask

    task automatic test_freeze();
        for (int i = 0; i < 11; i++) begin
            if (i >= 3 && i < 6)
                drive_a(1'b0, 1'($urandom), $urandom_range(0, 3), 4'($urandom));
            else
                drive_a(1'b1, 1'b1, 0, 4'($urandom));
            cycle();
            n_cmp++;
            if (oa !== ea || (i >= 3 && i < 6 && bus_a.q_valid !== 1'b0)) begin
                n_fail++; $display("FAIL freeze %0d: got %b want %b", i, oa, ea);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        int guard = 0;
        drive_a(1'b1, 1'b1, 0, 4'($urandom));
        cycle();
        while (!(m_scan[0] && m_qch[0] == 2) && guard < 40) begin
            cycle();
            guard++;
        end
        n_cmp++;
        if (guard >= 40) begin n_fail++; $display("FAIL reach_ch2: got q_ch %0d want 2", bus_a.q_ch); end
        #2 rst = 1'b1;
        #1;
        model_reset();
        snap();
        n_cmp++;
        if (oa !== ea || oa !== 6'b0) begin n_fail++; $display("FAIL async_rst_a: got %b want %b", oa, ea); end
        n_cmp++;
        if (ob !== eb) begin n_fail++; $display("FAIL async_rst_b: got %h want %h", ob, eb); end
        #2 rst = 1'b0;
        drive_a(1'b1, 1'b0, 1, 4'b0010);
        cycle();
        n_cmp++;
        if (oa !== ea || bus_a.q !== 1'b1 || bus_a.q_ch !== 2'd1) begin
            n_fail++; $display("FAIL post_rst_manual: got %b want %b", oa, ea);
        end
        drive_a(1'b1, 1'b1, 3, 4'($urandom));
        cycle();
        n_cmp++;
        if (oa !== ea || bus_a.q_ch !== 2'd0) begin
            n_fail++; $display("FAIL post_rst_scan: got %b want %b", oa, ea);
        end
    endtask

    task automatic test_mode_toggle();
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, 1'b1, 0, 4'($urandom));
            cycle();
        end
        drive_a(1'b1, 1'b0, $urandom_range(0, 3), 4'($urandom));
        cycle();
        n_cmp++;
        if (oa !== ea || bus_a.q_valid !== 1'b1) begin
            n_fail++; $display("FAIL toggle_manual: got %b want %b", oa, ea);
        end
        for (int j = 0; j <= A_D; j++) begin
            drive_a(1'b1, 1'b1, 0, 4'($urandom));
            cycle();
            n_cmp++;
            if (oa !== ea || bus_a.q_ch !== ((j < A_D) ? 2'd0 : 2'd1)) begin
                n_fail++; $display("FAIL toggle_reentry %0d: got %b want %b", j, oa, ea);
            end
        end
    endtask

    task automatic test_random();
        logic ma = 1'b0, mb = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) ma = ~ma;
            if ($urandom_range(0, 7) == 0) mb = ~mb;
            drive_a($urandom_range(0, 9) != 0, ma, $urandom_range(0, 3), 4'($urandom));
            drive_b($urandom_range(0, 9) != 0, mb, $urandom_range(0, 7), 40'({$urandom, $urandom}));
            cycle();
            n_cmp++;
            if (oa !== ea) begin n_fail++; $display("FAIL random_a %0d: got %b want %b", i, oa, ea); end
            n_cmp++;
            if (ob !== eb) begin n_fail++; $display("FAIL random_b %0d: got %h want %h", i, ob, eb); end
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_scan();
        test_sel_err();
        test_freeze();
        test_reset_mid_scan();
        test_mode_toggle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
